imm_encoder: RTL and testbench

- Inverse of the datapath immediate generator: packs register fields, function codes and an XLEN-wide immediate into a 32-bit RV instruction word, selected by instruction format.
- Used by the NPC self-test/trap-injection path to synthesise instructions such as jal, branches and lui at run time.
- Sequential and handshaked: validates the immediate's range and alignment, then presents the word on a valid/ready output held stable under backpressure.
- Keeps saturating counts of successful and rejected encodings.

---
 rtl/imm_encoder_if.sv | 33 +++
 rtl/imm_encoder.sv | 211 +++++++++++++++++++++
 tb/tb_imm_encoder.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_encoder_if.sv
// Request/response bundle for the instruction encoder: field inputs with a
// valid/ready request side and a valid/ready result side.
interface imm_encoder_if #(
    parameter int XLEN   = 64,
    parameter int TYPE_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [TYPE_W-1:0] in_sel;
    logic [6:0]        in_opcode;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [XLEN-1:0]   in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic              out_err;

    modport master (
        output in_valid, in_sel, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_inst, out_err
    );

    modport slave (
        input  in_valid, in_sel, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_inst, out_err
    );
endinterface

// File: rtl/imm_encoder.sv
// Packs register fields, function codes and an immediate into a 32-bit RV
// instruction word; rejects out-of-range or misaligned immediates.
module imm_encoder #(
    parameter int XLEN   = 64,
    parameter int TYPE_W = 4,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    imm_encoder_if.slave     bus,
    output logic [CNT_W-1:0] cnt_ok,
    output logic [CNT_W-1:0] cnt_err
);
    localparam logic [TYPE_W-1:0] ENUM_TYPE_R   = TYPE_W'(4'd0);
    localparam logic [TYPE_W-1:0] ENUM_TYPE_I   = TYPE_W'(4'd1);
    localparam logic [TYPE_W-1:0] ENUM_TYPE_I_M = TYPE_W'(4'd2);
    localparam logic [TYPE_W-1:0] ENUM_TYPE_I_J = TYPE_W'(4'd3);
    localparam logic [TYPE_W-1:0] ENUM_TYPE_S   = TYPE_W'(4'd4);
    localparam logic [TYPE_W-1:0] ENUM_TYPE_B   = TYPE_W'(4'd5);
    localparam logic [TYPE_W-1:0] ENUM_TYPE_J   = TYPE_W'(4'd6);
    localparam logic [TYPE_W-1:0] ENUM_TYPE_U_A = TYPE_W'(4'd7);
    localparam logic [TYPE_W-1:0] ENUM_TYPE_U_L = TYPE_W'(4'd8);
    localparam logic [TYPE_W-1:0] ENUM_TYPE_E   = TYPE_W'(4'd9);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_PACK  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    // True when imm is the sign extension of its low nbits bits.
    function automatic logic fits_signed(input logic [XLEN-1:0] imm, input int nbits);
        logic [XLEN-1:0] v;
        v = XLEN'($signed(imm) >>> (nbits - 32'sd1));
        return (v == {XLEN{1'b0}}) || (v == {XLEN{1'b1}});
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic [TYPE_W-1:0] r_sel;
    logic [6:0]        r_opcode;
    logic [4:0]        r_rd;
    logic [4:0]        r_rs1;
    logic [4:0]        r_rs2;
    logic [2:0]        r_funct3;
    logic [6:0]        r_funct7;
    logic [XLEN-1:0]   r_imm;
    logic              r_legal;
    logic              w_legal;
    logic [31:0]       w_inst;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [31:0]       r_out_inst;
    logic              r_out_err;
    logic [CNT_W-1:0]  r_cnt_ok;
    logic [CNT_W-1:0]  r_cnt_err;
    logic              w_accept;
    logic              w_deliver;

    // in_ready is only ever high in IDLE, so it alone qualifies acceptance.
    assign w_accept  = bus.in_valid & r_in_ready;
    assign w_deliver = (r_state == S_HOLD) & bus.out_ready;

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_inst  = r_out_inst;
    assign bus.out_err   = r_out_err;
    assign cnt_ok        = r_cnt_ok;
    assign cnt_err       = r_cnt_err;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_CHECK;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CHECK: w_state_nxt = S_PACK;
            S_PACK:  w_state_nxt = S_HOLD;
            S_HOLD: begin
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_HOLD;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request capture; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel    <= {TYPE_W{1'b0}};
            r_opcode <= 7'd0;
            r_rd     <= 5'd0;
            r_rs1    <= 5'd0;
            r_rs2    <= 5'd0;
            r_funct3 <= 3'd0;
            r_funct7 <= 7'd0;
            r_imm    <= {XLEN{1'b0}};
            r_legal  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sel    <= bus.in_sel;
                r_opcode <= bus.in_opcode;
                r_rd     <= bus.in_rd;
                r_rs1    <= bus.in_rs1;
                r_rs2    <= bus.in_rs2;
                r_funct3 <= bus.in_funct3;
                r_funct7 <= bus.in_funct7;
                r_imm    <= bus.in_imm;
            end
            if (r_state == S_CHECK) begin
                r_legal <= w_legal;
            end
        end
    end

    // Range and alignment rules per format.
    always_comb begin
        w_legal = 1'b0;
        case (r_sel)
            ENUM_TYPE_R, ENUM_TYPE_E:
                w_legal = 1'b1;
            ENUM_TYPE_I, ENUM_TYPE_I_M, ENUM_TYPE_I_J, ENUM_TYPE_S:
                w_legal = fits_signed(r_imm, 32'sd12);
            ENUM_TYPE_B:
                w_legal = fits_signed(r_imm, 32'sd13) & ~r_imm[0];
            ENUM_TYPE_J:
                w_legal = fits_signed(r_imm, 32'sd21) & ~r_imm[0];
            ENUM_TYPE_U_A, ENUM_TYPE_U_L:
                w_legal = fits_signed(r_imm, 32'sd32) & (r_imm[11:0] == 12'd0);
            default:
                w_legal = 1'b0;
        endcase
    end

    // Bit placement mirrors the immediate generator; unused fields stay zero.
    always_comb begin
        w_inst = 32'd0;
        case (r_sel)
            ENUM_TYPE_R:
                w_inst = {r_funct7, r_rs2, r_rs1, r_funct3, r_rd, r_opcode};
            ENUM_TYPE_I, ENUM_TYPE_I_M, ENUM_TYPE_I_J, ENUM_TYPE_E:
                w_inst = {r_imm[11:0], r_rs1, r_funct3, r_rd, r_opcode};
            ENUM_TYPE_S:
                w_inst = {r_imm[11:5], r_rs2, r_rs1, r_funct3, r_imm[4:0], r_opcode};
            ENUM_TYPE_B:
                w_inst = {r_imm[12], r_imm[10:5], r_rs2, r_rs1, r_funct3,
                          r_imm[4:1], r_imm[11], r_opcode};
            ENUM_TYPE_J:
                w_inst = {r_imm[20], r_imm[10:1], r_imm[11], r_imm[19:12], r_rd, r_opcode};
            ENUM_TYPE_U_A, ENUM_TYPE_U_L:
                w_inst = {r_imm[31:12], r_rd, r_opcode};
            default:
                w_inst = 32'd0;
        endcase
    end

    // Handshake outputs; the word is frozen from PACK until delivery.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_inst  <= 32'd0;
            r_out_err   <= 1'b0;
        end else begin
            r_in_ready <= (w_state_nxt == S_IDLE);
            if (r_state == S_PACK) begin
                r_out_valid <= 1'b1;
                r_out_inst  <= r_legal ? w_inst : 32'd0;
                r_out_err   <= ~r_legal;
            end else if (w_deliver) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Saturating delivery statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_ok  <= {CNT_W{1'b0}};
            r_cnt_err <= {CNT_W{1'b0}};
        end else if (w_deliver) begin
            if (r_out_err) begin
                r_cnt_err <= sat_inc(r_cnt_err);
            end else begin
                r_cnt_ok <= sat_inc(r_cnt_ok);
            end
        end
    end
endmodule

// File: tb/tb_imm_encoder.sv
// Directed and randomized bench for imm_encoder against a behavioural model.
module tb_imm_encoder;
    localparam int XLEN = 64;
    localparam logic [3:0] T_R = 4'd0, T_I = 4'd1, T_IM = 4'd2, T_IJ = 4'd3, T_S = 4'd4,
                           T_B = 4'd5, T_J = 4'd6, T_UA = 4'd7, T_UL = 4'd8, T_E = 4'd9;
    localparam longint U_MIN = -64'sd2147483648;
    localparam longint U_MAX = 64'sd2147483647;

    typedef struct {
        logic [31:0] inst;
        logic        err;
        int          acc_edge;
    } item_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cnt_ok, cnt_err;
    int          n_checks = 0;
    int          n_fail = 0;
    int          edge_n = 0;
    item_t       q[$];
    logic [31:0] exp_ok = 32'd0, exp_err = 32'd0;
    bit          seen_valid = 1'b0;
    bit          force_sat = 1'b0;
    bit          rnd_done = 1'b0;
    longint      bnd[14] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, 4096, -4098,
                             -1048576, 1048574, 1048576, -1048578, 64'sh8000_0000};

    always #5 clk = ~clk;

    imm_encoder_if #(.XLEN(XLEN), .TYPE_W(4)) ifc();

    imm_encoder #(.XLEN(XLEN), .TYPE_W(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .bus(ifc), .cnt_ok(cnt_ok), .cnt_err(cnt_err)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired (t=%0t)", nm, $time);
    endtask

    // Reference encoding: {err, inst} straight from the format rules.
    function automatic logic [32:0] model(input logic [3:0] sel, input logic [6:0] op,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [2:0] f3,
                                          input logic [6:0] f7, input longint imm);
        bit legal;
        longint unsigned u, w;
        u = imm;
        w = 0;
        case (sel)
            T_R:  begin legal = 1; w = longint'(f7) << 25; end
            T_E:  begin legal = 1; w = (u & 64'hFFF) << 20; end
            T_I, T_IM, T_IJ: begin
                legal = (imm >= -2048) && (imm <= 2047);
                w = (u & 64'hFFF) << 20;
            end
            T_S: begin
                legal = (imm >= -2048) && (imm <= 2047);
                w = (((u >> 5) & 64'h7F) << 25) | ((u & 64'h1F) << 7);
            end
            T_B: begin
                legal = (imm >= -4096) && (imm <= 4094) && (imm % 2 == 0);
                w = (((u >> 12) & 1) << 31) | (((u >> 5) & 64'h3F) << 25)
                  | (((u >> 1) & 64'hF) << 8) | (((u >> 11) & 1) << 7);
            end
            T_J: begin
                legal = (imm >= -1048576) && (imm <= 1048574) && (imm % 2 == 0);
                w = (((u >> 20) & 1) << 31) | (((u >> 1) & 64'h3FF) << 21)
                  | (((u >> 11) & 1) << 20) | (((u >> 12) & 64'hFF) << 12);
            end
            T_UA, T_UL: begin
                legal = (imm % 4096 == 0) && (imm >= U_MIN) && (imm <= U_MAX);
                w = u & 64'hFFFF_F000;
            end
            default: legal = 0;
        endcase
        if (!legal) return {1'b1, 32'd0};
        w = w | longint'(op);
        if (sel inside {T_R, T_I, T_IM, T_IJ, T_UA, T_UL, T_J, T_E}) w = w | (longint'(rd) << 7);
        if (sel inside {T_R, T_I, T_IM, T_IJ, T_S, T_B, T_E})
            w = w | (longint'(rs1) << 15) | (longint'(f3) << 12);
        if (sel inside {T_R, T_S, T_B}) w = w | (longint'(rs2) << 20);
        return {1'b0, w[31:0]};
    endfunction

    // Scoreboard: records accepted requests and deliveries at each active edge.
    task automatic scoreboard();
        item_t it;
        logic [32:0] m;
        forever begin
            @(posedge clk);
            edge_n++;
            if (rst) begin
                q.delete();
                exp_ok = 32'd0;
                exp_err = 32'd0;
                seen_valid = 0;
            end else begin
                if (force_sat) exp_ok = 32'hFFFF_FFFF;
                if (ifc.out_valid && ifc.out_ready && q.size() > 0) begin
                    it = q.pop_front();
                    if (it.err) exp_err = (exp_err == 32'hFFFF_FFFF) ? exp_err : exp_err + 1;
                    else        exp_ok  = (exp_ok  == 32'hFFFF_FFFF) ? exp_ok  : exp_ok + 1;
                    seen_valid = 0;
                end
                if (ifc.in_valid && ifc.in_ready) begin
                    m = model(ifc.in_sel, ifc.in_opcode, ifc.in_rd, ifc.in_rs1, ifc.in_rs2,
                              ifc.in_funct3, ifc.in_funct7, longint'(ifc.in_imm));
                    it.inst = m[31:0];
                    it.err = m[32];
                    it.acc_edge = edge_n;
                    q.push_back(it);
                end
            end
        end
    endtask

    // Compare process: checks outputs against the scoreboard every cycle.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (edge_n > 0 && !rst) begin
                chk("ready_while_valid", {63'd0, ifc.in_ready & ifc.out_valid}, 64'd0);
                if (!force_sat) begin
                    chk("cnt_ok", cnt_ok, exp_ok);
                    chk("cnt_err", cnt_err, exp_err);
                end
                if (ifc.out_valid) begin
                    if (q.size() == 0) begin
                        chk("spurious_valid", {63'd0, ifc.out_valid}, 64'd0);
                    end else begin
                        chk("out_inst", ifc.out_inst, q[0].inst);
                        chk("out_err", ifc.out_err, q[0].err);
                        if (!seen_valid) begin
                            chk("latency", edge_n, q[0].acc_edge + 2);
                            seen_valid = 1;
                        end
                    end
                end else if (q.size() > 0 && edge_n >= q[0].acc_edge + 2) begin
                    chk("missing_valid", {63'd0, ifc.out_valid}, 64'd1);
                end
            end
        end
    endtask

    task automatic scramble();
        ifc.in_sel    = 4'($urandom);
        ifc.in_opcode = 7'($urandom);
        ifc.in_rd     = 5'($urandom);
        ifc.in_rs1    = 5'($urandom);
        ifc.in_rs2    = 5'($urandom);
        ifc.in_funct3 = 3'($urandom);
        ifc.in_funct7 = 7'($urandom);
        ifc.in_imm    = {$urandom, $urandom};
    endtask

    task automatic set_req(input logic [3:0] sel, input logic [6:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                           input logic [6:0] f7, input longint imm);
        ifc.in_sel = sel; ifc.in_opcode = op; ifc.in_rd = rd; ifc.in_rs1 = rs1;
        ifc.in_rs2 = rs2; ifc.in_funct3 = f3; ifc.in_funct7 = f7; ifc.in_imm = imm;
        ifc.in_valid = 1'b1;
    endtask

    task automatic wait_accept();
        bit got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(posedge clk);
            if (ifc.in_ready && !rst) got = 1;
        end
        #1;
        if (!got) fail_now("accept_timeout");
    endtask

    task automatic send(input logic [3:0] sel, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input longint imm);
        set_req(sel, op, rd, rs1, rs2, f3, f7, imm);
        wait_accept();
        ifc.in_valid = 1'b0;
        scramble();
    endtask

    task automatic wait_valid();
        bit got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (ifc.out_valid) got = 1;
        end
        if (!got) fail_now("valid_timeout");
    endtask

    task automatic wait_idle();
        bit got = 0;
        for (int k = 0; k < 80 && !got; k++) begin
            @(negedge clk);
            if (q.size() == 0 && !ifc.out_valid) got = 1;
        end
        if (!got) fail_now("idle_timeout");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", ifc.out_valid, 64'd0);
        chk("rst_out_inst", ifc.out_inst, 64'd0);
        chk("rst_cnt_ok", cnt_ok, 64'd0);
        chk("rst_cnt_err", cnt_err, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready_low", ifc.in_ready, 64'd0);
        @(negedge clk);
        chk("rst_in_ready_high", ifc.in_ready, 64'd1);
    endtask

    task automatic directed(input string nm, input logic [3:0] sel, input logic [6:0] op,
                            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [2:0] f3, input longint imm,
                            input logic [31:0] ex_inst, input logic ex_err);
        send(sel, op, rd, rs1, rs2, f3, 7'd0, imm);
        wait_valid();
        chk({nm, "_inst"}, ifc.out_inst, ex_inst);
        chk({nm, "_err"}, ifc.out_err, ex_err);
        wait_idle();
    endtask

    task automatic rand_req();
        longint imm;
        logic [3:0] sel;
        sel = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        case ($urandom_range(0, 7))
            0: imm = longint'($urandom_range(0, 6000)) - 3000;
            1: imm = bnd[$urandom_range(0, 13)];
            2: imm = longint'($signed($urandom())) & ~longint'(4095);
            3: imm = (longint'($signed($urandom())) & ~longint'(4095)) + 1;
            4: imm = {$urandom, $urandom};
            5: imm = (longint'($urandom_range(0, 2097151)) - 1048576) & ~longint'(1);
            6: imm = longint'($urandom_range(0, 8191)) - 4096;
            default: imm = 0;
        endcase
        send(sel, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
             7'($urandom), imm);
    endtask

    initial begin
        ifc.in_valid = 1'b0;
        ifc.out_ready = 1'b1;
        scramble();
        fork
            scoreboard();
            monitor();
            begin
                #2000000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset in the middle of a held result.
        do_reset();
        ifc.out_ready = 1'b0;
        send(T_I, 7'h13, 5'd3, 5'd4, 5'd5, 3'd0, 7'd0, 5);
        wait_valid();
        repeat (2) @(negedge clk);
        do_reset();
        ifc.out_ready = 1'b1;

        directed("addi", T_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, -1, 32'hFFF0_0093, 1'b0);
        chk("addi_cnt_ok", cnt_ok, 64'd1);

        do_reset();
        directed("sw",  T_S,  7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 8,  32'h0020_A423, 1'b0);
        directed("beq", T_B,  7'h63, 5'd0, 5'd0, 5'd0, 3'd0, -4, 32'hFE00_0EE3, 1'b0);
        directed("jal", T_J,  7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 8,  32'h0080_00EF, 1'b0);
        directed("lui", T_UL, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 64'h1234_5000, 32'h1234_52B7, 1'b0);
        chk("sbju_cnt_ok", cnt_ok, 64'd4);

        directed("b_odd",  T_B,  7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 3,    32'd0, 1'b1);
        directed("i_2048", T_I,  7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 2048, 32'd0, 1'b1);
        directed("u_low",  T_UL, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 64'h1234_5001, 32'd0, 1'b1);
        chk("illegal_cnt_err", cnt_err, 64'd3);
        chk("illegal_cnt_ok", cnt_ok, 64'd4);

        // Backpressure with in_valid held high and inputs changing.
        ifc.out_ready = 1'b0;
        set_req(T_S, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 8);
        wait_accept();
        scramble();
        wait_valid();
        for (int k = 0; k < 5; k++) begin
            chk("bp_in_ready", ifc.in_ready, 64'd0);
            chk("bp_inst", ifc.out_inst, 64'h0020_A423);
            chk("bp_valid", ifc.out_valid, 64'd1);
            @(negedge clk);
        end
        ifc.out_ready = 1'b1;
        @(posedge clk);
        #1 ifc.in_valid = 1'b0;
        wait_idle();
        chk("bp_cnt_ok", cnt_ok, 64'd5);
        chk("bp_cnt_err", cnt_err, 64'd3);

        // Saturation of the good-encoding counter.
        force dut.r_cnt_ok = 32'hFFFF_FFFF;
        force_sat = 1'b1;
        @(posedge clk);
        #1;
        release dut.r_cnt_ok;
        force_sat = 1'b0;
        directed("sat_addi", T_I, 7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 100, 32'h0641_8113, 1'b0);
        chk("sat_cnt_ok", cnt_ok, 64'hFFFF_FFFF);

        // Randomized traffic with random consumer backpressure.
        do_reset();
        fork
            begin
                for (int n = 0; n < 150; n++) begin
                    rand_req();
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(negedge clk);
                    ifc.out_ready = ($urandom_range(0, 3) != 0);
                end
                ifc.out_ready = 1'b1;
            end
        join
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
